// File: rtl/spm_seq_pkg.sv
// Shared types and sizing helpers for the serial-parallel multiplier sequencer.
package spm_seq_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_SPM_LAT = 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLEAR = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Counter must hold the full run length without wrapping.
  function automatic int cnt_w(input int width, input int lat);
    return $clog2(2 * width + lat + 1);
  endfunction

endpackage

// File: rtl/spm_seq_shift.sv
// Right-shift register with parallel load; shifts in either sin or its own MSB.
module spm_seq_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         sin,
  input  logic         sign_fill,
  output logic [W-1:0] q,
  output logic         sout
);

  logic [W-1:0] q_q, q_d;
  logic         fill;

  always_comb begin
    fill = sign_fill ? q_q[W-1] : sin;
    q_d  = q_q;
    if (load) begin
      q_d = load_val;
    end else if (shift) begin
      q_d = {fill, q_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign sout = q_q[0];

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer for the spm array: clear, stream the multiplier serially, collect the product.
//   state | meaning
//   IDLE  | waiting for an operand pair
//   CLEAR | one-cycle synchronous clear of the array
//   RUN   | streaming multiplier bits, capturing product bits
//   DONE  | product presented until the consumer takes it
module spm_seq_ctrl
  import spm_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter bit SIGNED  = 1'b1,
  parameter int SPM_LAT = DEF_SPM_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_mc,
  input  logic [WIDTH-1:0]   in_mp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [WIDTH-1:0]   spm_x,
  output logic               spm_y,
  output logic               spm_clr,
  input  logic               spm_p,
  output logic               busy
);

  localparam int CW = cnt_w(WIDTH, SPM_LAT);
  localparam logic [CW-1:0] RUN_LAST = CW'(2 * WIDTH + SPM_LAT - 1);
  localparam logic [CW-1:0] LAT_C    = CW'(SPM_LAT);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic               spm_y_q, spm_y_d;
  logic               mp_load, mp_shift, mp_sout;
  logic               pr_load, pr_shift, pr_sout_unused;
  logic [WIDTH-1:0]   mp_par_unused;
  logic [2*WIDTH-1:0] pr_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    mp_load  = 1'b0;
    mp_shift = 1'b0;
    pr_load  = 1'b0;
    pr_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = in_mc;
          mp_load = 1'b1;
          pr_load = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_d    = '0;
        mp_shift = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        mp_shift = 1'b1;
        cnt_d    = cnt_q + CW'(1);
        // The first SPM_LAT product bits still belong to the cleared array.
        if (cnt_q >= LAT_C) begin
          pr_shift = 1'b1;
        end
        if (cnt_q == RUN_LAST) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
    // Bit 0 is registered one cycle ahead so RUN cycle n drives multiplier bit n.
    spm_y_d = (state_d == ST_RUN) ? mp_sout : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      spm_y_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      spm_y_q <= spm_y_d;
    end
  end

  spm_seq_shift #(.W(WIDTH)) u_mp_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (mp_load),
    .load_val  (in_mp),
    .shift     (mp_shift),
    .sin       (1'b0),
    .sign_fill (SIGNED),
    .q         (mp_par_unused),
    .sout      (mp_sout)
  );

  spm_seq_shift #(.W(2 * WIDTH)) u_prod_des (
    .clk       (clk),
    .rst       (rst),
    .load      (pr_load),
    .load_val  ('0),
    .shift     (pr_shift),
    .sin       (spm_p),
    .sign_fill (1'b0),
    .q         (pr_q),
    .sout      (pr_sout_unused)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign spm_clr   = (state_q == ST_CLEAR);
  assign spm_x     = x_q;
  assign spm_y     = spm_y_q;
  assign out_prod  = pr_q;

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Directed bench: one unsigned and one signed sequencer, each driving a behavioural spm array.
module tb_spm_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid[2], in_ready[2], out_valid[2], out_ready[2];
  logic        spm_y[2], spm_clr[2], spm_p[2], busy[2];
  logic [7:0]  in_mc[2], in_mp[2], spm_x[2];
  logic [15:0] out_prod[2];

  int n_cmp = 0;
  int n_err = 0;

  spm_seq_ctrl #(.WIDTH(8), .SIGNED(1'b0), .SPM_LAT(1)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_mc(in_mc[0]), .in_mp(in_mp[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_prod(out_prod[0]), .spm_x(spm_x[0]), .spm_y(spm_y[0]), .spm_clr(spm_clr[0]),
    .spm_p(spm_p[0]), .busy(busy[0])
  );

  spm_seq_ctrl #(.WIDTH(8), .SIGNED(1'b1), .SPM_LAT(1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_mc(in_mc[1]), .in_mp(in_mp[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_prod(out_prod[1]), .spm_x(spm_x[1]), .spm_y(spm_y[1]), .spm_clr(spm_clr[1]),
    .spm_p(spm_p[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural array: accumulate x*2^i for each set serial bit, emit bit i one cycle later.
  logic [31:0] acc[2];
  logic [31:0] nxt_m;
  int          bi[2];

  function automatic logic [31:0] spm_step(input logic [7:0] x, input bit sgn, input logic y,
                                           input int i, input logic [31:0] a);
    logic [31:0] xe;
    xe = sgn ? {{24{x[7]}}, x} : {24'd0, x};
    if (y && i < 32) return a + (xe << i);
    return a;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst || spm_clr[d]) begin
        acc[d]   <= '0;
        bi[d]    <= 0;
        spm_p[d] <= 1'b0;
      end else begin
        nxt_m     = spm_step(spm_x[d], (d == 1), spm_y[d], bi[d], acc[d]);
        acc[d]   <= nxt_m;
        spm_p[d] <= (bi[d] < 32) ? nxt_m[5'(bi[d])] : 1'b0;
        if (bi[d] < 40) bi[d] <= bi[d] + 1;
      end
    end
  end

  // Records the serial multiplier stream and clear pulse widths.
  logic [15:0] ybits[2];
  int          rc[2];
  int          clr_cnt[2];

  initial begin
    rc[0] = 100; rc[1] = 100;
    clr_cnt[0] = 0; clr_cnt[1] = 0;
    ybits[0] = '0; ybits[1] = '0;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (spm_clr[d]) begin
        rc[d] = 0;
        clr_cnt[d] = clr_cnt[d] + 1;
      end else if (rc[d] < 16) begin
        ybits[d][rc[d]] = spm_y[d];
        rc[d] = rc[d] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a pair from a negedge; returns at the negedge of the handshake cycle.
  task automatic start(input int d, input logic [7:0] mc, input logic [7:0] mp);
    in_mc[d] = mc;
    in_mp[d] = mp;
    in_valid[d] = 1'b1;
    clr_cnt[d] = 0;
    for (int n = 0; n < 40; n++) begin
      if (in_ready[d]) return;
      @(negedge clk);
    end
    chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Counts negedges until out_valid; lat=-1 on timeout.
  task automatic wait_valid(input int d, output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      in_valid[d] = 1'b0;
      if (out_valid[d]) begin
        lat = n;
        return;
      end
    end
  endtask

  task automatic take(input int d);
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
  endtask

  task automatic run_txn(input int d, input logic [7:0] mc, input logic [7:0] mp,
                         output logic [15:0] prod, output int lat);
    start(d, mc, mp);
    wait_valid(d, lat);
    prod = out_prod[d];
    take(d);
  endtask

  logic [15:0] prod;
  int          lat;
  bit          stable;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; in_mc[d] = '0; in_mp[d] = '0;
    end
    #1;
    chk("rst_in_ready", in_ready[0], 1);
    chk("rst_out_valid", out_valid[0], 0);
    chk("rst_busy", busy[1], 0);
    chk("rst_spm_clr", spm_clr[1], 0);
    chk("rst_spm_xy", {spm_x[0], spm_y[0]}, 0);
    chk("rst_out_prod", out_prod[1], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Unsigned 13*11, latency and clear pulse width.
    run_txn(0, 8'd13, 8'd11, prod, lat);
    chk("u_13x11", prod, 16'h008F);
    chk("u_latency", lat, 19);
    chk("u_clr_width", clr_cnt[0], 1);

    // Signed products.
    run_txn(1, 8'hFD, 8'h05, prod, lat);
    chk("s_m3x5", prod, 16'hFFF1);
    run_txn(1, 8'h80, 8'h80, prod, lat);
    chk("s_min_sq", prod, 16'h4000);

    // Extension bits: zero for unsigned, sign for signed.
    run_txn(0, 8'hFF, 8'hFF, prod, lat);
    chk("u_ff_sq", prod, 16'hFE01);
    chk("u_ext_bits", ybits[0][15:8], 8'h00);
    chk("u_low_bits", ybits[0][7:0], 8'hFF);
    run_txn(1, 8'h03, 8'hFF, prod, lat);
    chk("s_3xm1", prod, 16'hFFFD);
    chk("s_ext_bits", ybits[1][15:8], 8'hFF);

    // Back-pressure in DONE with a competing input.
    start(0, 8'h21, 8'h03);
    wait_valid(0, lat);
    chk("bp_latency", lat, 19);
    prod = out_prod[0];
    chk("bp_prod", prod, 16'h0063);
    in_valid[0] = 1'b1; in_mc[0] = 8'h55; in_mp[0] = 8'h02;
    stable = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!(out_valid[0] === 1'b1 && out_prod[0] === prod && in_ready[0] === 1'b0)) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    in_valid[0] = 1'b0;
    take(0);
    chk("bp_idle", busy[0], 0);
    chk("bp_not_accepted", spm_x[0], 8'h21);

    // Reset in the middle of RUN (cnt=5).
    start(0, 8'h12, 8'h34);
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      in_valid[0] = 1'b0;
    end
    chk("abort_busy_before", busy[0], 1);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready[0], 1);
    chk("abort_busy", busy[0], 0);
    chk("abort_clr", spm_clr[0], 0);
    @(negedge clk);
    rst = 1'b0;
    stable = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0) stable = 1'b0;
    end
    chk("abort_no_valid", stable, 1);
    run_txn(0, 8'd7, 8'd9, prod, lat);
    chk("abort_next_7x9", prod, 16'h003F);

    // Next pair offered during the output handshake cycle.
    start(1, 8'h06, 8'h07);
    wait_valid(1, lat);
    chk("b2b_a_prod", out_prod[1], 16'h002A);
    out_ready[1] = 1'b1;
    in_valid[1] = 1'b1; in_mc[1] = 8'hFE; in_mp[1] = 8'h03;
    @(negedge clk);
    out_ready[1] = 1'b0;
    chk("b2b_gap_busy", busy[1], 0);
    chk("b2b_gap_x", spm_x[1], 8'h06);
    start(1, 8'hFE, 8'h03);
    @(negedge clk);
    in_valid[1] = 1'b0;
    chk("b2b_busy_again", busy[1], 1);
    chk("b2b_b_x", spm_x[1], 8'hFE);
    wait_valid(1, lat);
    chk("b2b_b_latency", lat, 18);
    chk("b2b_b_prod", out_prod[1], 16'hFFFA);
    take(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
